// File: rtl/nes_port_pkg.sv
// Shared constants for the NES controller port block: button bit positions,
// turbo enable positions, read counter limit and output reset value.
package nes_port_pkg;

   localparam int unsigned NUM_BUTTONS = 8;

   localparam int unsigned BTN_A      = 0;
   localparam int unsigned BTN_B      = 1;
   localparam int unsigned BTN_SELECT = 2;
   localparam int unsigned BTN_START  = 3;
   localparam int unsigned BTN_UP     = 4;
   localparam int unsigned BTN_DOWN   = 5;
   localparam int unsigned BTN_LEFT   = 6;
   localparam int unsigned BTN_RIGHT  = 7;

   localparam int unsigned TURBO_A_EN = 0;
   localparam int unsigned TURBO_B_EN = 1;

   localparam logic [3:0] CNT_MAX    = 4'd8;
   localparam logic [4:0] DOUT_RESET = 5'b00001;

endpackage

// File: rtl/nes_joy_shifter.sv
// One controller port: turbo-masked parallel load, serial shift on reads,
// saturating read counter and the registered D0 bit the CPU sees.
module nes_joy_shifter
   import nes_port_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   strobe,
   input  logic                   rd,
   input  logic [NUM_BUTTONS-1:0] joy,
   input  logic [1:0]             turbo,
   input  logic                   turbo_phase,
   output logic                   data_bit
);

   logic [NUM_BUTTONS-1:0] sr;
   logic [3:0]             cnt;
   logic [NUM_BUTTONS-1:0] masked;

   always_comb begin
      masked = joy;
      if (turbo[TURBO_A_EN] && !turbo_phase) masked[BTN_A] = 1'b0;
      if (turbo[TURBO_B_EN] && !turbo_phase) masked[BTN_B] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr       <= '1;
         cnt      <= CNT_MAX;
         data_bit <= DOUT_RESET[0];
      end else begin
         if (strobe) begin
            sr  <= masked;
            cnt <= '0;
         end else if (rd) begin
            sr <= {1'b1, sr[NUM_BUTTONS-1:1]};
            if (cnt != CNT_MAX) cnt <= cnt + 4'd1;
         end
         // once 8 bits have gone out the port reads as 1 regardless of sr
         data_bit <= (cnt < CNT_MAX) ? sr[0] : 1'b1;
      end
   end

endmodule

// File: rtl/nes_port_ctrl.sv
// NES $4016/$4017 controller ports: two joypad shifters, shared turbo phase
// generator and zapper mapping for port 2.
module nes_port_ctrl
   import nes_port_pkg::*;
#(
   parameter int unsigned TURBO_DIV = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   strobe,
   input  logic                   rd0,
   input  logic                   rd1,
   input  logic [NUM_BUTTONS-1:0] joy0,
   input  logic [NUM_BUTTONS-1:0] joy1,
   input  logic [1:0]             turbo0,
   input  logic [1:0]             turbo1,
   input  logic                   zapper_sel,
   input  logic                   zapper_light,
   input  logic                   zapper_trigger,
   output logic [4:0]             dout0,
   output logic [4:0]             dout1,
   output logic                   zapper_active
);

   localparam int unsigned EDGE_W = $clog2(TURBO_DIV + 1);

   logic              strobe_q;
   logic [EDGE_W-1:0] edge_cnt;
   logic              turbo_phase;
   logic              zap_trigger_q;
   logic              zap_light_q;
   logic              bit0;
   logic              bit1;

   always_ff @(posedge clk) begin
      if (reset) begin
         strobe_q      <= 1'b0;
         edge_cnt      <= '0;
         turbo_phase   <= 1'b1;
         zapper_active <= 1'b0;
         zap_trigger_q <= 1'b0;
         zap_light_q   <= 1'b0;
      end else begin
         strobe_q      <= strobe;
         zap_trigger_q <= zapper_trigger;
         zap_light_q   <= zapper_light;
         if (strobe) zapper_active <= zapper_sel;
         if (strobe_q && !strobe) begin
            if (edge_cnt == EDGE_W'(TURBO_DIV - 1)) begin
               edge_cnt    <= '0;
               turbo_phase <= ~turbo_phase;
            end else begin
               edge_cnt <= edge_cnt + 1'b1;
            end
         end
      end
   end

   nes_joy_shifter u_port0 (
      .clk         (clk),
      .reset       (reset),
      .strobe      (strobe),
      .rd          (rd0),
      .joy         (joy0),
      .turbo       (turbo0),
      .turbo_phase (turbo_phase),
      .data_bit    (bit0)
   );

   nes_joy_shifter u_port1 (
      .clk         (clk),
      .reset       (reset),
      .strobe      (strobe),
      .rd          (rd1),
      .joy         (joy1),
      .turbo       (turbo1),
      .turbo_phase (turbo_phase),
      .data_bit    (bit1)
   );

   // all mux inputs are registers, so dout1 keeps a pure register-to-pin path
   assign dout0 = {4'b0000, bit0};
   assign dout1 = zapper_active ? {zap_trigger_q, zap_light_q, 3'b000}
                                : {4'b0000, bit1};

endmodule

// File: tb/tb_nes_port_ctrl.sv
// Directed bench for nes_port_ctrl: serial reads, strobe hold, zapper mapping,
// turbo phase, dual-port reads and reset behaviour.
module tb_nes_port_ctrl;

   logic       clk;
   logic       reset;
   logic       strobe;
   logic       rd0, rd1;
   logic [7:0] joy0, joy1;
   logic [1:0] turbo0, turbo1;
   logic       zapper_sel, zapper_light, zapper_trigger;
   logic [4:0] dout0, dout1;
   logic       zapper_active;

   int total = 0;
   int bad   = 0;

   nes_port_ctrl #(.TURBO_DIV(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .strobe         (strobe),
      .rd0            (rd0),
      .rd1            (rd1),
      .joy0           (joy0),
      .joy1           (joy1),
      .turbo0         (turbo0),
      .turbo1         (turbo1),
      .zapper_sel     (zapper_sel),
      .zapper_light   (zapper_light),
      .zapper_trigger (zapper_trigger),
      .dout0          (dout0),
      .dout1          (dout1),
      .zapper_active  (zapper_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_strobe();
      strobe = 1'b1;
      tick();
      tick();
      strobe = 1'b0;
      tick();
      tick();
   endtask

   task automatic read0(output logic v);
      v = dout0[0];
      rd0 = 1'b1;
      tick();
      rd0 = 1'b0;
      tick();
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (dout0 !== 5'b00001) begin bad++; $display("FAIL reset_dout0 got=%b exp=00001", dout0); end
      total++; if (dout1 !== 5'b00001) begin bad++; $display("FAIL reset_dout1 got=%b exp=00001", dout1); end
      total++; if (zapper_active !== 1'b0) begin bad++; $display("FAIL reset_zap got=%b exp=0", zapper_active); end
   endtask

   task automatic test_shift_a();
      logic v;
      logic exp_seq [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      joy0 = 8'b0000_0001;
      pulse_strobe();
      for (int i = 0; i < 9; i++) begin
         read0(v);
         total++; if (v !== exp_seq[i]) begin bad++; $display("FAIL shift_a read%0d got=%b exp=%b", i, v, exp_seq[i]); end
      end
      total++; if (dout0[4:1] !== 4'b0000) begin bad++; $display("FAIL dout0_upper got=%b exp=0000", dout0[4:1]); end
   endtask

   task automatic test_strobe_hold();
      logic v;
      joy0 = 8'h80;
      strobe = 1'b1;
      tick(); tick();
      for (int i = 0; i < 3; i++) begin
         rd0 = 1'b1; tick(); rd0 = 1'b0; tick();
         total++; if (dout0[0] !== 1'b0) begin bad++; $display("FAIL strobe_hold%0d got=%b exp=0", i, dout0[0]); end
      end
      strobe = 1'b0;
      tick(); tick();
      for (int i = 0; i < 8; i++) begin
         read0(v);
         total++; if (v !== (i == 7)) begin bad++; $display("FAIL strobe_hold_read%0d got=%b exp=%b", i, v, (i == 7)); end
      end
   endtask

   task automatic test_zapper();
      zapper_sel = 1'b1; zapper_light = 1'b0; zapper_trigger = 1'b1;
      strobe = 1'b1;
      tick();
      total++; if (zapper_active !== 1'b1) begin bad++; $display("FAIL zap_active got=%b exp=1", zapper_active); end
      total++; if (dout1 !== 5'b10000) begin bad++; $display("FAIL zap_dout1 got=%b exp=10000", dout1); end
      strobe = 1'b0;
      zapper_light = 1'b1; zapper_trigger = 1'b0;
      tick();
      total++; if (dout1 !== 5'b01000) begin bad++; $display("FAIL zap_light got=%b exp=01000", dout1); end
   endtask

   task automatic test_zapper_latch();
      joy1 = 8'h00;
      zapper_sel = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rd1 = 1'b1; tick(); rd1 = 1'b0; tick();
      end
      total++; if (zapper_active !== 1'b1) begin bad++; $display("FAIL zap_hold got=%b exp=1", zapper_active); end
      pulse_strobe();
      total++; if (zapper_active !== 1'b0) begin bad++; $display("FAIL zap_release got=%b exp=0", zapper_active); end
      total++; if (dout1 !== 5'b00000) begin bad++; $display("FAIL zap_port2 got=%b exp=00000", dout1); end
   endtask

   task automatic test_dual();
      logic [1:0] got;
      logic [1:0] exp_v [3] = '{2'b10, 2'b01, 2'b00};
      joy0 = 8'h01; joy1 = 8'h02;
      pulse_strobe();
      for (int i = 0; i < 3; i++) begin
         got = {dout0[0], dout1[0]};
         rd0 = 1'b1; rd1 = 1'b1; tick();
         rd0 = 1'b0; rd1 = 1'b0; tick(); tick();
         total++; if (got !== exp_v[i]) begin bad++; $display("FAIL dual_read%0d got=%b exp=%b", i, got, exp_v[i]); end
      end
   endtask

   task automatic test_turbo();
      do_reset();
      joy0 = 8'h01; turbo0 = 2'b01;
      for (int f = 0; f < 16; f++) begin
         pulse_strobe();
         total++; if (dout0[0] !== (f < 8)) begin bad++; $display("FAIL turbo_frame%0d got=%b exp=%b", f, dout0[0], (f < 8)); end
      end
      turbo0 = 2'b00;
   endtask

   task automatic test_reset_mid();
      logic v;
      logic exp_seq [3] = '{1'b1, 1'b0, 1'b1};
      joy0 = 8'h05;
      pulse_strobe();
      for (int i = 0; i < 3; i++) begin
         read0(v);
         total++; if (v !== exp_seq[i]) begin bad++; $display("FAIL pre_reset_read%0d got=%b exp=%b", i, v, exp_seq[i]); end
      end
      joy0 = 8'h00;
      reset = 1'b1; strobe = 1'b1; rd0 = 1'b1;
      tick();
      reset = 1'b0; strobe = 1'b0; rd0 = 1'b0;
      total++; if (dout0 !== 5'b00001) begin bad++; $display("FAIL mid_reset_dout0 got=%b exp=00001", dout0); end
      total++; if (dout1 !== 5'b00001) begin bad++; $display("FAIL mid_reset_dout1 got=%b exp=00001", dout1); end
      tick();
      for (int i = 0; i < 2; i++) begin
         read0(v);
         total++; if (v !== 1'b1) begin bad++; $display("FAIL post_reset_read%0d got=%b exp=1", i, v); end
      end
      pulse_strobe();
      read0(v);
      total++; if (v !== 1'b0) begin bad++; $display("FAIL after_strobe_read got=%b exp=0", v); end
   endtask

   initial begin
      reset = 1'b1; strobe = 1'b0; rd0 = 1'b0; rd1 = 1'b0;
      joy0 = '0; joy1 = '0; turbo0 = '0; turbo1 = '0;
      zapper_sel = 1'b0; zapper_light = 1'b0; zapper_trigger = 1'b0;
      tick();
      test_reset();
      test_shift_a();
      test_strobe_hold();
      test_zapper();
      test_zapper_latch();
      test_dual();
      test_turbo();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
